// File: rtl/pattern_merge_pipe.sv
`default_nettype none
// =============================================================================
// Module   : pattern_merge_pipe
// Purpose  : Elastic valid/ready pipeline of per-token NOR/NAND pattern stages
//            with collapsing bubbles and a wrapping emitted-token counter.
// Revision : 1.0 - initial release
// =============================================================================
module pattern_merge_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                       blif_clk_net,
  input  logic                       blif_reset_net,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DEPTH-1:0]           in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           emit_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // Bit i combines with bit i+1; the top bit wraps around to bit 0.
  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] x,
                                                input logic             nand_sel);
    logic [WIDTH-1:0] nbr;
    nbr = {x[0], x[WIDTH-1:1]};
    return nand_sel ? ~(x & nbr) : ~(x | nbr);
  endfunction

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0] mode_q  [DEPTH];
  logic [WIDTH-1:0] x_in    [DEPTH];
  logic [DEPTH-1:0] mode_in [DEPTH];
  logic [WIDTH-1:0] y_d     [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [OCC_W-1:0] occ;
  logic             out_hs;

  // Advance resolves from the output end back towards the input.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int k = DEPTH-2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~flush & (~v_q[0] | adv[0]);
  assign out_hs   = v_q[DEPTH-1] & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign x_in[k]    = in_data;
      assign mode_in[k] = in_mode;
      assign load[k]    = in_valid & in_ready;
    end else begin : g_body
      assign x_in[k]    = data_q[k-1];
      assign mode_in[k] = mode_q[k-1];
      assign load[k]    = adv[k-1];
    end
    assign y_d[k] = pattern(x_in[k], mode_in[k][k]);
  end

  always_comb begin
    v_d   = flush ? '0 : (load | (v_q & ~adv));
    cnt_d = cnt_q + CNT_W'(out_hs);
    occ   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(v_q[k]);
    end
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      // Data follows loads even during flush; only the valid bits are cleared.
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          data_q[k] <= y_d[k];
          mode_q[k] <= mode_in[k];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ;
  assign emit_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_merge_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_pattern_merge_pipe
// Purpose  : Directed stimulus with a token-queue reference model for
//            pattern_merge_pipe (WIDTH=8, DEPTH=3, CNT_W=4).
// Revision : 1.0 - initial release
// =============================================================================
module tb_pattern_merge_pipe;

  localparam int W = 8;
  localparam int D = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [D-1:0]  in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] emit_cnt;

  int n_chk = 0;
  int n_err = 0;

  pattern_merge_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mode        (in_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .occupancy      (occupancy),
    .emit_cnt       (emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference transform: each stage combines neighbouring bits bit by bit.
  function automatic logic [W-1:0] pat_model(input logic [W-1:0] din, input logic [D-1:0] mode);
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = din;
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < W; i++) begin
        if (mode[k]) y[i] = ~(x[i] & x[(i+1)%W]);
        else         y[i] = ~(x[i] | x[(i+1)%W]);
      end
      x = y;
    end
    return x;
  endfunction

  // Model: in-flight tokens ordered oldest first, each with a stage position
  // 1..D; a token can only move up to one slot behind the token ahead.
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } tok_t;

  tok_t q[$];
  int   mcnt = 0;

  always @(negedge clk) begin
    logic exp_ov, exp_rdy, ohs, ihs;
    int   lim, np;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      exp_ov  = (q.size() > 0) && (q[0].pos == D);
      exp_rdy = !flush && ((q.size() < D) || out_ready);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("emit_cnt", 32'(emit_cnt), 32'(mcnt % 16));
      if (exp_ov) chk("out_data", 32'(out_data), 32'(q[0].d));
      ohs = exp_ov && out_ready;
      ihs = in_valid && exp_rdy;
      if (ohs) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (flush) begin
        q.delete();
      end else begin
        lim = D;
        for (int i = 0; i < q.size(); i++) begin
          np = q[i].pos + 1;
          if (np > lim) np = lim;
          q[i].pos = np;
          lim = np - 1;
        end
        if (ihs) q.push_back('{d: pat_model(in_data, in_mode), pos: 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill3();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hA5 + 8'(i * 17);
      in_mode = 3'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [W-1:0] stok [4] = '{8'h01, 8'h00, 8'hFF, 8'h0F};
  logic [D-1:0] smode[4] = '{3'b000, 3'b000, 3'b000, 3'b001};

  initial begin
    int idx;
    int c0;
    logic acc;

    // Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_emit_cnt", 32'(emit_cnt), 32'd0);
    tick();

    // Single token, NOR on every stage
    in_valid = 1'b1; in_data = 8'h01; in_mode = 3'b000;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h3F);
    tick();
    chk("t1_cnt", 32'(emit_cnt), 32'd1);

    // Back-to-back tokens; mode changes afterwards leave them untouched
    in_valid = 1'b1; in_data = 8'h00; in_mode = 3'b000;
    tick();
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0; in_mode = 3'b111;
    tick();
    chk("t2_first", 32'(out_data), 32'hFF);
    tick();
    chk("t2_second", 32'(out_data), 32'h00);
    tick();

    // Mixed NAND/NOR token
    in_valid = 1'b1; in_data = 8'h0F; in_mode = 3'b001;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t3_mixed", 32'(out_data), 32'h7C);
    tick(); tick();

    // Stall with four offered tokens, then release
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = stok[idx]; in_mode = smode[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    chk("stall_accepted", 32'(idx), 32'd3);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_occ", 32'(occupancy), 32'd3);
    out_ready = 1'b1;
    #1;
    chk("full_accept", 32'(in_ready), 32'd1);
    chk("rel_0", 32'(out_data), 32'h3F);
    tick();
    in_valid = 1'b0;
    chk("rel_1", 32'(out_data), 32'hFF);
    tick();
    chk("rel_2", 32'(out_data), 32'h00);
    tick();
    chk("rel_3", 32'(out_data), 32'h7C);
    tick();
    chk("rel_empty", 32'(out_valid), 32'd0);

    // Flush while full, output stalled
    fill3();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    c0 = int'(emit_cnt);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(emit_cnt), 32'(c0));

    // Flush while full, output handshake in the same cycle
    fill3();
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    c0 = int'(emit_cnt);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_hs_cnt", 32'(emit_cnt), 32'((c0 + 1) % 16));
    chk("flush_hs_occ", 32'(occupancy), 32'd0);
    tick();

    // Asynchronous reset between edges while full
    fill3();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_cnt", 32'(emit_cnt), 32'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; in_mode = 3'b000;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("arst_first", 32'(out_data), 32'h3F);
    tick();

    // Counter wrap: 17 emitted tokens from a fresh reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i * 29 + 3);
      in_mode = 3'(i % 8);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("wrap_cnt", 32'(emit_cnt), 32'd1);
    chk("wrap_occ", 32'(occupancy), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
